exec_issue: RTL and testbench

EXEC_ISSUE -- requirements
Module: exec_issue

---
 rtl/exec_issue_if.sv | 38 +++
 rtl/exec_issue.sv | 180 ++++++++++++++++++
 tb/tb_exec_issue.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/exec_issue_if.sv
// exec_issue_if: groups the fetch-side and memory-side handshake signals of exec_issue.
//   Fetch side : instruction_data_i/addr_i/valid_i in; dequeue_o, restart_o, restart_addr_o out.
//   Memory side: load_store_valid_o, store_en_o, load_store_addr_o, store_data_o out;
//                load_data_i, load_data_valid_i in.
// Suffixes are named from the point of view of exec_issue.
//   slave  : used by exec_issue.
//   master : used by whatever drives it (fetch FIFO / memory model / testbench).
interface exec_issue_if #(
  parameter int I_WIDTH = 17,
  parameter int A_WIDTH = 10
);
  logic [I_WIDTH-1:0] instruction_data_i;
  logic [A_WIDTH-1:0] instruction_addr_i;
  logic               instruction_valid_i;
  logic               dequeue_o;
  logic               restart_o;
  logic [A_WIDTH-1:0] restart_addr_o;
  logic               load_store_valid_o;
  logic               store_en_o;
  logic [A_WIDTH-1:0] load_store_addr_o;
  logic [I_WIDTH-1:0] store_data_o;
  logic [I_WIDTH-1:0] load_data_i;
  logic               load_data_valid_i;

  modport slave (
    input  instruction_data_i, instruction_addr_i, instruction_valid_i,
    input  load_data_i, load_data_valid_i,
    output dequeue_o, restart_o, restart_addr_o,
    output load_store_valid_o, store_en_o, load_store_addr_o, store_data_o
  );

  modport master (
    output instruction_data_i, instruction_addr_i, instruction_valid_i,
    output load_data_i, load_data_valid_i,
    input  dequeue_o, restart_o, restart_addr_o,
    input  load_store_valid_o, store_en_o, load_store_addr_o, store_data_o
  );
endinterface

// File: rtl/exec_issue.sv
// exec_issue: in-order single-accumulator execute stage sitting behind a fetch FIFO.
// Retires one instruction per dequeue, resolves branches against the fetch-side
// prediction bit, issues single-beat load/store requests and redirects fetch on
// mispredict (one restart pulse followed by FLUSH_CYCLES dead cycles).
// Ports:
//   clk, reset        : single clock, synchronous active-high reset.
//   bus (slave)       : fetch and memory handshakes, see exec_issue_if.
//   acc_o             : accumulator.
//   halted_o          : 1 while parked in HALT.
//   retire_count_o    : retired instruction count, wraps at 2^16.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// EXEC     | dequeue and execute the FIFO head when valid
// MEM_REQ  | one-cycle load/store strobe on the memory bus
// MEM_WAIT | load issued, waiting for load_data_valid_i
// RESTART  | one-cycle restart_o pulse to fetch
// FLUSH    | FLUSH_CYCLES dead cycles while fetch refills
// HALT     | parked until reset
module exec_issue #(
  parameter int I_WIDTH      = 17,
  parameter int A_WIDTH      = 10,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  exec_issue_if.slave        bus,
  output logic [I_WIDTH-1:0] acc_o,
  output logic               halted_o,
  output logic [15:0]        retire_count_o
);

  typedef enum logic [2:0] {
    S_EXEC     = 3'd0,
    S_MEM_REQ  = 3'd1,
    S_MEM_WAIT = 3'd2,
    S_RESTART  = 3'd3,
    S_FLUSH    = 3'd4,
    S_HALT     = 3'd5
  } state_t;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_LD   = 3'b010;
  localparam logic [2:0] OP_ST   = 3'b011;
  localparam logic [2:0] OP_BZ   = 3'b100;
  localparam logic [2:0] OP_BNZ  = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b110;

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_t             state_q, state_d;
  logic [I_WIDTH-1:0] acc_q, acc_d;
  logic [15:0]        retire_q, retire_d;
  logic [A_WIDTH-1:0] restart_addr_q, restart_addr_d;
  logic [A_WIDTH-1:0] ls_addr_q, ls_addr_d;
  logic               is_store_q, is_store_d;
  logic [FC_W-1:0]    flush_cnt_q, flush_cnt_d;

  // Instruction fields
  logic               pred_taken;
  logic [2:0]         opcode;
  logic [9:0]         imm10;
  logic [4:0]         off5;
  logic [I_WIDTH-1:0] imm_sext;
  logic [A_WIDTH-1:0] off_sext;
  logic [A_WIDTH-1:0] br_target;
  logic [A_WIDTH-1:0] fall_through;
  logic               acc_zero;
  logic               dequeue;
  logic               unused_fields;

  assign pred_taken    = bus.instruction_data_i[16];
  assign opcode        = bus.instruction_data_i[15:13];
  assign imm10         = bus.instruction_data_i[9:0];
  assign off5          = bus.instruction_data_i[4:0];
  assign unused_fields = ^bus.instruction_data_i[12:10];

  assign imm_sext     = {{(I_WIDTH-10){imm10[9]}}, imm10};
  assign off_sext     = {{(A_WIDTH-5){off5[4]}}, off5};
  assign br_target    = bus.instruction_addr_i + off_sext;
  assign fall_through = bus.instruction_addr_i + A_WIDTH'(1);
  assign acc_zero     = (acc_q == '0);

  // Reset wins over a valid head so nothing is popped in the reset cycle.
  assign dequeue = (state_q == S_EXEC) && bus.instruction_valid_i && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_EXEC;
      acc_q          <= '0;
      retire_q       <= '0;
      restart_addr_q <= '0;
      ls_addr_q      <= '0;
      is_store_q     <= 1'b0;
      flush_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      retire_q       <= retire_d;
      restart_addr_q <= restart_addr_d;
      ls_addr_q      <= ls_addr_d;
      is_store_q     <= is_store_d;
      flush_cnt_q    <= flush_cnt_d;
    end
  end

  always_comb begin
    logic taken;
    state_d        = state_q;
    acc_d          = acc_q;
    retire_d       = retire_q;
    restart_addr_d = restart_addr_q;
    ls_addr_d      = ls_addr_q;
    is_store_d     = is_store_q;
    flush_cnt_d    = flush_cnt_q;
    taken          = 1'b0;

    unique case (state_q)
      S_EXEC: begin
        if (dequeue) begin
          // LD is the only instruction that retires later, on data capture.
          if (opcode != OP_LD) retire_d = retire_q + 16'd1;
          case (opcode)
            OP_ADDI: acc_d = acc_q + imm_sext;
            OP_LD, OP_ST: begin
              ls_addr_d  = A_WIDTH'(imm10);
              is_store_d = (opcode == OP_ST);
              state_d    = S_MEM_REQ;
            end
            OP_BZ, OP_BNZ: begin
              taken = (opcode == OP_BZ) ? acc_zero : !acc_zero;
              if (taken != pred_taken) begin
                restart_addr_d = taken ? br_target : fall_through;
                state_d        = S_RESTART;
              end
            end
            OP_HALT: state_d = S_HALT;
            default: ;
          endcase
        end
      end
      S_MEM_REQ: state_d = is_store_q ? S_EXEC : S_MEM_WAIT;
      S_MEM_WAIT: begin
        if (bus.load_data_valid_i) begin
          acc_d    = bus.load_data_i;
          retire_d = retire_q + 16'd1;
          state_d  = S_EXEC;
        end
      end
      S_RESTART: begin
        if (FLUSH_CYCLES == 0) begin
          state_d = S_EXEC;
        end else begin
          flush_cnt_d = FC_W'(FLUSH_CYCLES - 1);
          state_d     = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (flush_cnt_q == '0) state_d = S_EXEC;
        else flush_cnt_d = flush_cnt_q - FC_W'(1);
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_EXEC;
    endcase
  end

  assign bus.dequeue_o          = dequeue;
  assign bus.restart_o          = (state_q == S_RESTART);
  assign bus.restart_addr_o     = restart_addr_q;
  assign bus.load_store_valid_o = (state_q == S_MEM_REQ);
  assign bus.store_en_o         = (state_q == S_MEM_REQ) && is_store_q;
  assign bus.load_store_addr_o  = ls_addr_q;
  assign bus.store_data_o       = acc_q;

  assign acc_o          = acc_q;
  assign halted_o       = (state_q == S_HALT);
  assign retire_count_o = retire_q;

endmodule

// File: tb/tb_exec_issue.sv
module tb_exec_issue;
  localparam int IW = 17;
  localparam int AW = 10;
  localparam logic [16:0] NOP_I = 17'h0E000;

  logic          clk = 1'b0;
  logic          reset;
  logic [IW-1:0] acc;
  logic          halted;
  logic [15:0]   retire;

  int tests = 0;
  int failed = 0;

  exec_issue_if #(.I_WIDTH(IW), .A_WIDTH(AW)) bus ();

  exec_issue #(.I_WIDTH(IW), .A_WIDTH(AW), .FLUSH_CYCLES(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .acc_o          (acc),
    .halted_o       (halted),
    .retire_count_o (retire)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [16:0] instr;
    logic [9:0]  addr;
    logic [16:0] exp_acc;
    logic        exp_rst;
    logic [9:0]  exp_raddr;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [16:0] instr, input logic [9:0] addr);
    bus.instruction_data_i  = instr;
    bus.instruction_addr_i  = addr;
    bus.instruction_valid_i = 1'b1;
    tick();
    bus.instruction_valid_i = 1'b0;
  endtask

  initial begin
    // {instr, addr, exp_acc, exp_restart, exp_restart_addr}
    vecs[0]  = '{17'h023FF, 10'h000, 17'h1FFFF, 1'b0, 10'h000}; // ADDI -1
    vecs[1]  = '{17'h02001, 10'h001, 17'h00000, 1'b0, 10'h000}; // ADDI 1, wrap to 0
    vecs[2]  = '{17'h0801D, 10'h010, 17'h00000, 1'b1, 10'h00D}; // BZ -3 P=0 taken
    vecs[3]  = '{17'h02005, 10'h00D, 17'h00005, 1'b0, 10'h00D}; // ADDI 5
    vecs[4]  = '{17'h18000, 10'h3FF, 17'h00005, 1'b1, 10'h000}; // BZ P=1 not taken, wrap
    vecs[5]  = '{17'h08000, 10'h3FF, 17'h00005, 1'b0, 10'h000}; // BZ P=0 not taken
    vecs[6]  = '{17'h1A004, 10'h100, 17'h00005, 1'b0, 10'h000}; // BNZ P=1 taken
    vecs[7]  = '{17'h0A003, 10'h3FE, 17'h00005, 1'b1, 10'h001}; // BNZ P=0 taken, wrap
    vecs[8]  = '{17'h0E123, 10'h002, 17'h00005, 1'b0, 10'h001}; // NOP (111)
    vecs[9]  = '{17'h023FA, 10'h003, 17'h1FFFF, 1'b0, 10'h001}; // ADDI -6
    vecs[10] = '{17'h1801F, 10'h005, 17'h1FFFF, 1'b1, 10'h006}; // BZ P=1 not taken
    vecs[11] = '{17'h0A010, 10'h200, 17'h1FFFF, 1'b1, 10'h1F0}; // BNZ -16 P=0 taken

    reset = 1'b1;
    bus.instruction_data_i  = '0;
    bus.instruction_addr_i  = '0;
    bus.instruction_valid_i = 1'b0;
    bus.load_data_i         = '0;
    bus.load_data_valid_i   = 1'b0;
    tick();
    tick();
    bus.instruction_valid_i = 1'b1;
    #1;
    chk("dequeue_in_reset", 32'(bus.dequeue_o), 32'd0);
    bus.instruction_valid_i = 1'b0;
    reset = 1'b0;
    chk("reset_acc", 32'(acc), 32'd0);
    chk("reset_retire", 32'(retire), 32'd0);
    chk("reset_raddr", 32'(bus.restart_addr_o), 32'd0);
    chk("reset_lsaddr", 32'(bus.load_store_addr_o), 32'd0);
    chk("reset_halted", 32'(halted), 32'd0);
    chk("reset_restart", 32'(bus.restart_o), 32'd0);
    chk("reset_lsv", 32'(bus.load_store_valid_o), 32'd0);
    chk("reset_store_en", 32'(bus.store_en_o), 32'd0);

    // Table-driven single-cycle instructions
    for (int i = 0; i < 12; i++) begin
      bus.instruction_data_i  = vecs[i].instr;
      bus.instruction_addr_i  = vecs[i].addr;
      bus.instruction_valid_i = 1'b1;
      #1;
      chk("vec_dequeue", 32'(bus.dequeue_o), 32'd1);
      tick();
      bus.instruction_valid_i = 1'b0;
      chk("vec_acc", 32'(acc), 32'(vecs[i].exp_acc));
      chk("vec_retire", 32'(retire), 32'(i + 1));
      chk("vec_restart", 32'(bus.restart_o), 32'(vecs[i].exp_rst));
      chk("vec_raddr", 32'(bus.restart_addr_o), 32'(vecs[i].exp_raddr));
      if (vecs[i].exp_rst) begin
        bus.instruction_data_i  = NOP_I;
        bus.instruction_valid_i = 1'b1;
        #1;
        chk("rst_dq_c0", 32'(bus.dequeue_o), 32'd0);
        tick();
        chk("rst_pulse_off", 32'(bus.restart_o), 32'd0);
        chk("rst_dq_c1", 32'(bus.dequeue_o), 32'd0);
        tick();
        chk("rst_dq_c2", 32'(bus.dequeue_o), 32'd0);
        tick();
        chk("rst_dq_back", 32'(bus.dequeue_o), 32'd1);
        bus.instruction_valid_i = 1'b0;
        chk("rst_retire_hold", 32'(retire), 32'(i + 1));
      end
    end

    // ADDI 8 -> acc 7, then ST 0x030
    issue(17'h02008, 10'h010);
    chk("addi8_acc", 32'(acc), 32'h00007);
    issue(17'h06030, 10'h011);
    chk("st_lsv", 32'(bus.load_store_valid_o), 32'd1);
    chk("st_store_en", 32'(bus.store_en_o), 32'd1);
    chk("st_addr", 32'(bus.load_store_addr_o), 32'h030);
    chk("st_data", 32'(bus.store_data_o), 32'h00007);
    chk("st_retire", 32'(retire), 32'd14);
    bus.instruction_data_i  = NOP_I;
    bus.instruction_valid_i = 1'b1;
    #1;
    chk("st_dq_blocked", 32'(bus.dequeue_o), 32'd0);
    tick();
    chk("st_lsv_pulse", 32'(bus.load_store_valid_o), 32'd0);
    chk("st_back_exec", 32'(bus.dequeue_o), 32'd1);
    bus.instruction_valid_i = 1'b0;

    // LD 0x020, data 4 cycles after the strobe; stray data during the strobe ignored
    issue(17'h04020, 10'h012);
    chk("ld_lsv", 32'(bus.load_store_valid_o), 32'd1);
    chk("ld_store_en", 32'(bus.store_en_o), 32'd0);
    chk("ld_addr", 32'(bus.load_store_addr_o), 32'h020);
    chk("ld_retire_wait", 32'(retire), 32'd14);
    bus.load_data_i       = 17'h15555;
    bus.load_data_valid_i = 1'b1;
    tick();
    bus.load_data_valid_i = 1'b0;
    chk("ld_lsv_pulse", 32'(bus.load_store_valid_o), 32'd0);
    bus.instruction_data_i  = NOP_I;
    bus.instruction_valid_i = 1'b1;
    #1;
    chk("ld_dq_blocked", 32'(bus.dequeue_o), 32'd0);
    tick();
    tick();
    tick();
    bus.load_data_i       = 17'h0ABCD;
    bus.load_data_valid_i = 1'b1;
    #1;
    chk("ld_dq_blocked2", 32'(bus.dequeue_o), 32'd0);
    chk("ld_acc_pre", 32'(acc), 32'h00007);
    bus.instruction_valid_i = 1'b0;
    tick();
    bus.load_data_valid_i = 1'b0;
    chk("ld_acc", 32'(acc), 32'h0ABCD);
    chk("ld_retire", 32'(retire), 32'd15);
    bus.instruction_valid_i = 1'b1;
    #1;
    chk("ld_dq_back", 32'(bus.dequeue_o), 32'd1);
    bus.instruction_valid_i = 1'b0;
    bus.load_data_i       = 17'h11111;
    bus.load_data_valid_i = 1'b1;
    tick();
    bus.load_data_valid_i = 1'b0;
    chk("exec_ld_ignored", 32'(acc), 32'h0ABCD);
    chk("exec_ld_retire", 32'(retire), 32'd15);

    // Reset while in MEM_WAIT, then late load data
    issue(17'h04040, 10'h013);
    tick();
    reset = 1'b1;
    tick();
    bus.instruction_valid_i = 1'b1;
    bus.load_data_i       = 17'h12345;
    bus.load_data_valid_i = 1'b1;
    #1;
    chk("rst_mw_dq", 32'(bus.dequeue_o), 32'd0);
    tick();
    reset = 1'b0;
    bus.instruction_valid_i = 1'b0;
    chk("rst_mw_acc", 32'(acc), 32'd0);
    chk("rst_mw_retire", 32'(retire), 32'd0);
    chk("rst_mw_lsaddr", 32'(bus.load_store_addr_o), 32'd0);
    chk("rst_mw_raddr", 32'(bus.restart_addr_o), 32'd0);
    chk("rst_mw_lsv", 32'(bus.load_store_valid_o), 32'd0);
    tick();
    bus.load_data_valid_i = 1'b0;
    chk("late_data_acc", 32'(acc), 32'd0);
    chk("late_data_retire", 32'(retire), 32'd0);

    // HALT parks until reset
    issue(17'h0C000, 10'h020);
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_retire", 32'(retire), 32'd1);
    bus.instruction_data_i  = 17'h02001;
    bus.instruction_valid_i = 1'b1;
    #1;
    chk("halt_dq", 32'(bus.dequeue_o), 32'd0);
    tick();
    tick();
    chk("halt_dq_later", 32'(bus.dequeue_o), 32'd0);
    chk("halt_still", 32'(halted), 32'd1);
    chk("halt_acc", 32'(acc), 32'd0);
    chk("halt_retire_hold", 32'(retire), 32'd1);
    bus.instruction_valid_i = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("halt_reset", 32'(halted), 32'd0);
    chk("halt_reset_retire", 32'(retire), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
